sd_cmd: RTL

SD_CMD -- requirements
Module: sd_cmd

---
 rtl/sd_cmd.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd.sv
// SD SPI-mode command sequencer: sends 0xFF, the 6-byte command frame, then polls for R1.
// Optional macro SD_CMD_KEEPCS_EN adds a keep_cs input that holds cs low after the command.
module sd_cmd #(
    parameter int unsigned NCR = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic [5:0]  cmd,
    input  logic [31:0] arg,
    input  logic [6:0]  crc,
`ifdef SD_CMD_KEEPCS_EN
    input  logic        keep_cs,
`endif
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout,
    output logic        cs,
    output logic        spi_tx,
    output logic        spi_rx,
    output logic [7:0]  spi_d,
    input  logic [7:0]  spi_q
);

    typedef enum logic [2:0] {StIdle, StPre, StFrame, StPoll, StDrain, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [6:0]  crc_q, crc_d;
    logic        keep_q, keep_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  r1_q, r1_d;
    logic        timeout_q, timeout_d;
    logic        cs_q, cs_d;
    logic        spi_tx_q, spi_tx_d;
    logic        spi_rx_q, spi_rx_d;
    logic [7:0]  spi_d_q, spi_d_d;
    logic [4:0]  gap_q, gap_d;
    logic [2:0]  idx_q, idx_d;
    logic        polled_q, polled_d;
    logic        smp_en_q, smp_en_d;
    logic [7:0]  smp_q, smp_d;
    logic [7:0]  frame_byte;

    always_comb begin
        case (idx_q)
            3'd0:    frame_byte = {2'b01, cmd_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            3'd5:    frame_byte = {crc_q, 1'b1};
            default: frame_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        crc_d     = crc_q;
        keep_d    = keep_q;
        busy_d    = busy_q;
        done_d    = done_q;
        r1_d      = r1_q;
        timeout_d = timeout_q;
        cs_d      = cs_q;
        spi_tx_d  = spi_tx_q;
        spi_rx_d  = spi_rx_q;
        spi_d_d   = spi_d_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        polled_d  = polled_q;
        smp_en_d  = smp_en_q;
        smp_d     = smp_q;
        if (ce) begin
            spi_tx_d = 1'b0;
            spi_rx_d = 1'b0;
            done_d   = 1'b0;
            // gap counts the 16 ticks after a strobe before the next may issue
            if (gap_q != 5'd0) gap_d = gap_q - 5'd1;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        cmd_d     = cmd;
                        arg_d     = arg;
                        crc_d     = crc;
`ifdef SD_CMD_KEEPCS_EN
                        keep_d    = keep_cs;
`else
                        keep_d    = 1'b0;
`endif
                        busy_d    = 1'b1;
                        cs_d      = 1'b0;
                        r1_d      = 8'hFF;
                        timeout_d = 1'b0;
                        gap_d     = 5'd0;
                        idx_d     = 3'd0;
                        polled_d  = 1'b0;
                        smp_en_d  = 1'b0;
                        smp_d     = 8'd0;
                        state_d   = StPre;
                    end
                end
                StPre: begin
                    if (gap_q == 5'd0) begin
                        spi_tx_d = 1'b1;
                        spi_d_d  = 8'hFF;
                        gap_d    = 5'd16;
                        idx_d    = 3'd0;
                        state_d  = StFrame;
                    end
                end
                StFrame: begin
                    if (gap_q == 5'd0) begin
                        spi_tx_d = 1'b1;
                        spi_d_d  = frame_byte;
                        gap_d    = 5'd16;
                        if (idx_q == 3'd5) state_d = StPoll;
                        else               idx_d   = idx_q + 3'd1;
                    end
                end
                StPoll: begin
                    // spi_q lags one byte, so the first poll strobe yields no sample
                    if (spi_rx_q && smp_en_q) begin
                        if (!spi_q[7]) begin
                            r1_d    = spi_q;
                            state_d = StDrain;
                        end else if (smp_q == 8'(NCR - 1)) begin
                            r1_d      = 8'hFF;
                            timeout_d = 1'b1;
                            state_d   = StDrain;
                        end else begin
                            smp_d = smp_q + 8'd1;
                        end
                    end else if (gap_q == 5'd0) begin
                        spi_rx_d = 1'b1;
                        spi_d_d  = 8'hFF;
                        gap_d    = 5'd16;
                        smp_en_d = polled_q;
                        polled_d = 1'b1;
                    end
                end
                StDrain: begin
                    if (gap_q == 5'd0) state_d = StEnd;
                end
                StEnd: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cs_d    = ~keep_q;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cmd_q     <= 6'd0;
            arg_q     <= 32'd0;
            crc_q     <= 7'd0;
            keep_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r1_q      <= 8'hFF;
            timeout_q <= 1'b0;
            cs_q      <= 1'b1;
            spi_tx_q  <= 1'b0;
            spi_rx_q  <= 1'b0;
            spi_d_q   <= 8'hFF;
            gap_q     <= 5'd0;
            idx_q     <= 3'd0;
            polled_q  <= 1'b0;
            smp_en_q  <= 1'b0;
            smp_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            crc_q     <= crc_d;
            keep_q    <= keep_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            r1_q      <= r1_d;
            timeout_q <= timeout_d;
            cs_q      <= cs_d;
            spi_tx_q  <= spi_tx_d;
            spi_rx_q  <= spi_rx_d;
            spi_d_q   <= spi_d_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            polled_q  <= polled_d;
            smp_en_q  <= smp_en_d;
            smp_q     <= smp_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign r1      = r1_q;
    assign timeout = timeout_q;
    assign cs      = cs_q;
    assign spi_tx  = spi_tx_q;
    assign spi_rx  = spi_rx_q;
    assign spi_d   = spi_d_q;

endmodule
